// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns an op_sel plus register/immediate fields into a
// 32-bit word and queues it in a 2-entry FIFO toward a valid/ready consumer.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err_illegal,
    input  logic        err_clear,
    output logic [15:0] issued_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and a producer holds its payload until the transfer.

    logic [31:0] enc_word;
    logic        illegal_op;

    always_comb begin
        enc_word   = '0;
        illegal_op = 1'b0;
        case (op_sel)
            4'd0:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            4'd1:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
            4'd2:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
            4'd3:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
            4'd4:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
            4'd5:    enc_word = {6'b100011, rs, rt, imm};
            4'd6:    enc_word = {6'b101011, rs, rt, imm};
            4'd7:    enc_word = {6'b001000, rs, rt, imm};
            4'd8:    enc_word = {6'b001100, rs, rt, imm};
            4'd9:    enc_word = {6'b001101, rs, rt, imm};
            4'd10:   enc_word = {6'b001110, rs, rt, imm};
            4'd11:   enc_word = {6'b000100, rs, rt, imm};
            4'd12:   enc_word = {6'b000101, rs, rt, imm};
            4'd13:   enc_word = {6'b001111, 5'b00000, rt, imm};
            4'd14:   enc_word = {6'b000010, target};
            default: illegal_op = 1'b1;
        endcase
    end

    // slot0 is always the head; a pop shifts slot1 down.
    logic [31:0] slot0;
    logic [31:0] slot1;
    logic [1:0]  count;
    logic        accept;
    logic        push;
    logic        pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign instr     = out_valid ? slot0 : 32'h0000_0000;
    assign accept    = in_valid & in_ready;
    assign push      = accept & ~illegal_op;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= enc_word;
                    else               slot1 <= enc_word;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                // push with pop only happens with one entry held (full blocks push)
                2'b11:   slot0 <= enc_word;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                  err_illegal <= 1'b0;
        else if (accept & illegal_op) err_illegal <= 1'b1;
        else if (err_clear)          err_illegal <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)   issued_cnt <= '0;
        else if (pop) issued_cnt <= issued_cnt + 16'd1;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus random traffic, with a
// scoreboard queue of expected words checked by an independent monitor.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err_illegal;
    logic        err_clear;
    logic [15:0] issued_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [15:0] exp_cnt = '0;
    logic        exp_err = 1'b0;
    logic        armed   = 1'b0;
    logic        rand_ready = 1'b0;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .err_illegal(err_illegal), .err_clear(err_clear), .issued_cnt(issued_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference encoding straight from the opcode/funct tables
    function automatic logic [31:0] ref_encode(input logic [3:0] op, input logic [4:0] f_rs,
                                               input logic [4:0] f_rt, input logic [4:0] f_rd,
                                               input logic [15:0] f_imm, input logic [25:0] f_tgt);
        logic [5:0] funct_tab [0:4];
        logic [5:0] opc_tab   [0:7];
        funct_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        opc_tab   = '{6'b100011, 6'b101011, 6'b001000, 6'b001100,
                      6'b001101, 6'b001110, 6'b000100, 6'b000101};
        if (op <= 4)       return {6'd0, f_rs, f_rt, f_rd, 5'd0, funct_tab[op]};
        else if (op <= 12) return {opc_tab[op - 5], f_rs, f_rt, f_imm};
        else if (op == 13) return {6'b001111, 5'd0, f_rt, f_imm};
        else               return {6'b000010, f_tgt};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_fields();
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        imm = 16'($urandom); target = 26'($urandom);
        op_sel = 4'($urandom);
    endtask

    // driver: present a request, wait for acceptance, push the expected word
    task automatic push_req(input logic [3:0] op, input logic [4:0] a_rs, input logic [4:0] a_rt,
                            input logic [4:0] a_rd, input logic [15:0] a_imm,
                            input logic [25:0] a_tgt);
        logic acc;
        bit   done;
        done = 0;
        op_sel = op; rs = a_rs; rt = a_rt; rd = a_rd; imm = a_imm; target = a_tgt;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            acc = in_ready & rst_n;
            @(posedge clk);
            if (acc) begin
                if (op != 4'd15) exp_q.push_back(ref_encode(op, a_rs, a_rt, a_rd, a_imm, a_tgt));
                done = 1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready never rose for op %0d", op);
        end
        #1;
        in_valid = 1'b0;
        scramble_fields();
    endtask

    task automatic push_random(input bit legal_only);
        logic [3:0] op;
        op = legal_only ? 4'($urandom_range(0, 14)) : 4'($urandom_range(0, 15));
        push_req(op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
    endtask

    // monitor: checks flags every cycle and pops the scoreboard on each transfer
    initial begin
        logic pop_now, ill_now, clr_now, rst_now;
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
                chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
                chk("issued_cnt", 32'(issued_cnt), 32'(exp_cnt));
                chk("err_illegal", 32'(err_illegal), 32'(exp_err));
                if (!out_valid) chk("instr_idle", instr, 32'h0);
            end
            pop_now = armed & rst_n & out_valid & out_ready;
            if (pop_now) begin
                if (exp_q.size() == 0) chk("unexpected_word", instr, 32'hxxxx_xxxx);
                else                   chk("instr", instr, exp_q.pop_front());
            end
            ill_now = rst_n & in_valid & in_ready & (op_sel == 4'd15);
            clr_now = err_clear;
            rst_now = !rst_n;
            @(posedge clk);
            if (rst_now) begin
                exp_q.delete();
                exp_cnt = '0;
                exp_err = 1'b0;
                armed   = 1'b1;
            end else begin
                if (pop_now) exp_cnt = exp_cnt + 16'd1;
                if (ill_now)      exp_err = 1'b1;
                else if (clr_now) exp_err = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clear = 1'b0;
        scramble_fields();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_cnt", 32'(issued_cnt), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        sync();

        // encode: add $3, $1, $2
        out_ready = 1'b1;
        push_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        @(negedge clk);
        chk("add_word", instr, 32'h0022_1820);
        chk("add_valid", 32'(out_valid), 32'h1);
        sync();
        @(negedge clk);
        chk("add_cnt", 32'(issued_cnt), 32'h1);
        sync();

        // I-type and jump
        push_req(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
        @(negedge clk);
        chk("lw_word", instr, 32'h8FA8_0004);
        sync();
        push_req(4'd14, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0010);
        @(negedge clk);
        chk("j_word", instr, 32'h0800_0010);
        sync();

        // backpressure: beq then lui while the consumer stalls
        out_ready = 1'b0;
        push_req(4'd11, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        push_req(4'd13, 5'd0, 5'd5, 5'd0, 16'h1234, 26'h0);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        chk("bp_head", instr, 32'h1022_FFFF);
        sync();
        out_ready = 1'b1;
        sync();
        @(negedge clk);
        chk("bp_second", instr, 32'h3C05_1234);
        sync();
        sync();

        // illegal op handling
        out_ready = 1'b0;
        push_random(1'b1);
        push_req(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        @(negedge clk);
        chk("ill_set", 32'(err_illegal), 32'h1);
        chk("ill_fifo_unchanged", 32'(in_ready), 32'h1);
        chk("ill_head_valid", 32'(out_valid), 32'h1);
        sync();
        err_clear = 1'b1;
        sync();
        err_clear = 1'b0;
        @(negedge clk);
        chk("ill_cleared", 32'(err_illegal), 32'h0);
        sync();
        push_req(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        err_clear = 1'b1;
        push_req(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        err_clear = 1'b0;
        @(negedge clk);
        chk("ill_set_wins", 32'(err_illegal), 32'h1);
        sync();
        err_clear = 1'b1;
        out_ready = 1'b1;
        sync();
        err_clear = 1'b0;
        sync();

        // random traffic with random backpressure and clears
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            err_clear = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 4) == 0) sync();
            else                           push_random(1'b0);
            err_clear = 1'b0;
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (4) sync();

        // mid-operation reset with two words queued
        out_ready = 1'b0;
        push_random(1'b1);
        push_random(1'b1);
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_cnt", 32'(issued_cnt), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
        chk("mid_rst_err", 32'(err_illegal), 32'h0);
        sync();

        // issued_cnt wrap: 65535 transfers then one more
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) push_random(1'b1);
        sync();
        @(negedge clk);
        chk("cnt_full", 32'(issued_cnt), 32'h0000_FFFF);
        sync();
        push_random(1'b1);
        sync();
        @(negedge clk);
        chk("cnt_wrap", 32'(issued_cnt), 32'h0);
        sync();

        repeat (3) sync();
        chk("drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is synchronous and active-low.
REQ-002 Ports SHALL be as follows:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- op_sel  input  4  operation select; encodings in REQ-007
- rs  input  5  source register
- rt  input  5  second source / I-type destination
- rd  input  5  R-type destination
- imm  input  16  immediate / branch offset
- target  input  26  jump target
- out_valid  output  1  instr holds a valid word
- out_ready  input  1  consumer accepts instr
- instr  output  32  encoded MIPS instruction word
- err_illegal  output  1  sticky illegal-op flag
- err_clear  input  1  clears err_illegal
- issued_cnt  output  16  count of words accepted by the consumer

Function
REQ-003 The block SHALL accept a request on any rising edge where in_valid and in_ready are both 1.
REQ-004 The block SHALL hold accepted words in a 2-entry FIFO, ordered first in, first out.
REQ-005 in_ready SHALL equal 1 exactly when the FIFO holds fewer than 2 entries; a pop in the same cycle SHALL NOT raise in_ready while the FIFO is full.
REQ-006 out_valid SHALL equal 1 exactly when the FIFO is non-empty; instr SHALL present the head entry; a word SHALL leave the FIFO on a rising edge where out_valid and out_ready are both 1.
REQ-007 Words SHALL be encoded per op_sel as follows:
- R-type (0 add, 1 sub, 2 and, 3 or, 4 slt): {000000, rs, rt, rd, 00000, funct}, with funct = 100000, 100010, 100100, 100101, 101010 respectively.
- I-type: {opcode, rs, rt, imm}, with 5 lw = 100011, 6 sw = 101011, 7 addi = 001000, 8 andi = 001100, 9 ori = 001101, 10 xori = 001110, 11 beq = 000100, 12 bne = 000101.
- 13 lui: {001111, 00000, rt, imm}.
- 14 j: {000010, target}.
REQ-008 op_sel = 15 SHALL be treated as an illegal operation:
- the handshake completes;
- nothing is enqueued;
- err_illegal is set to 1 on the next edge.
REQ-009 err_illegal SHALL stay at 1 until reset, or until an edge where err_clear = 1 and no illegal request is accepted in that same edge; a simultaneous set and clear SHALL leave the flag at 1.
REQ-010 Latency: a word accepted at edge N SHALL appear on instr with out_valid = 1 after edge N when the FIFO was empty before edge N.
REQ-011 Simultaneous push and pop with 1 entry held SHALL leave the occupancy at 1, with the new word at the head after the edge.
REQ-012 Simultaneous push and pop with 0 entries held SHALL NOT occur, because out_valid = 0 when the FIFO is empty.
REQ-013 issued_cnt SHALL increment by 1 on each edge where out_valid and out_ready are both 1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-014 instr SHALL read 32'h00000000 while out_valid = 0.
REQ-015 Field inputs SHALL be sampled only at acceptance; changes to them while the word is queued SHALL NOT affect it.

Reset
REQ-016 While rst_n = 0 at an edge, the block SHALL empty the FIFO and drive:
- out_valid = 0
- instr = 0
- err_illegal = 0
- issued_cnt = 0
- in_ready = 1 from the following cycle
REQ-017 A reset asserted mid-operation SHALL discard all queued words without emitting them, and no handshake SHALL complete on a reset edge.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Encode: op_sel = 0, rs = 1, rt = 2, rd = 3, out_ready = 1 -> next cycle instr = 0x00221820, out_valid = 1, then issued_cnt = 1.
- I-type and jump: op_sel = 5, rs = 29, rt = 8, imm = 0x0004 -> instr = 0x8FA80004; op_sel = 14, target = 0x0000010 -> instr = 0x08000010.
- Backpressure: out_ready = 0, push beq (rs = 1, rt = 2, imm = 0xFFFF) then lui (rt = 5, imm = 0x1234) -> in_ready = 0; raise out_ready -> instr = 0x1022FFFF, then 0x3C051234, in order.
- Illegal: op_sel = 15 accepted -> err_illegal = 1, FIFO unchanged; err_clear = 1 -> err_illegal = 0; err_clear with a simultaneous illegal op -> flag stays 1.
- Counter wrap: preload issued_cnt to 0xFFFF via 65535 pops, pop once more -> issued_cnt = 0x0000.
- Mid-op reset: two words queued, rst_n = 0 for one edge -> out_valid = 0, instr = 0, issued_cnt = 0, in_ready = 1 on the next cycle.
